// File: rtl/lab1_sw_pkg.sv
// Shared constants and helpers for the lab 1 slide-switch conditioner.
package lab1_sw_pkg;

  localparam int SW_WIDTH              = 4;
  localparam int DEFAULT_STABLE_CYCLES = 500000;
  localparam int DEFAULT_SYNC_STAGES   = 2;

  // Smallest counter width able to hold the value n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/lab1_sw_debounce_bit.sv
// One switch bit: synchroniser chain, stability counter and the accepted level flop.
// Optional edge strobe flop is built only when LAB1_SW_EDGE_EVT_EN is defined.
module lab1_sw_debounce_bit
  import lab1_sw_pkg::*;
#(
  parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int CNT_W         = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_in,
  output logic sw_out,
  output logic idle
`ifdef LAB1_SW_EDGE_EVT_EN
  ,
  output logic edge_pulse
`endif
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_next;
  logic                   take;

  assign s = sync[SYNC_STAGES-1];

  // Plain flop-to-flop synchroniser chain; nothing sits between the stages.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], sw_in};
    end
  end

  // Count consecutive cycles the synchronised level disagrees with the accepted level;
  // agreement cancels any pending change, reaching the last count accepts the new level.
  always_comb begin
    cnt_next = '0;
    take     = 1'b0;
    if (s != sw_out) begin
      if (cnt >= LAST) begin
        take = 1'b1;
      end else begin
        cnt_next = cnt + 1'b1;
      end
    end
  end

  // Counter, accepted level and idle flag all update together so idle reflects this cycle's count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      sw_out <= 1'b0;
      idle   <= 1'b1;
    end else begin
      cnt  <= cnt_next;
      idle <= (cnt_next == '0);
      if (take) begin
        sw_out <= s;
      end
    end
  end

`ifdef LAB1_SW_EDGE_EVT_EN
  // Strobe lands in the same cycle the level flop takes its new value, for either direction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_pulse <= 1'b0;
    end else begin
      edge_pulse <= take;
    end
  end
`endif

endmodule

// File: rtl/lab1_switch_debounce.sv
// Slide-switch conditioner feeding the 4-bit switch PIO: per-bit synchronise + debounce.
// Define LAB1_SW_EDGE_EVT_EN to add the edge_pulse toggle-strobe output.
module lab1_switch_debounce
  import lab1_sw_pkg::*;
#(
  parameter int WIDTH         = SW_WIDTH,
  parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int CNT_W         = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic             all_stable
`ifdef LAB1_SW_EDGE_EVT_EN
  ,
  output logic [WIDTH-1:0] edge_pulse
`endif
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (STABLE_CYCLES < 1) begin : g_bad_stable
    $error("STABLE_CYCLES must be at least 1");
  end
  if (CNT_W < cnt_width(STABLE_CYCLES)) begin : g_bad_cnt_w
    $error("CNT_W too narrow for STABLE_CYCLES");
  end

  logic [WIDTH-1:0] idle;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    lab1_sw_debounce_bit #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES),
      .CNT_W        (CNT_W)
    ) u_bit (
      .clk       (clk),
      .reset     (reset),
      .sw_in     (sw_in[i]),
      .sw_out    (sw_out[i]),
      .idle      (idle[i])
`ifdef LAB1_SW_EDGE_EVT_EN
      ,
      .edge_pulse(edge_pulse[i])
`endif
    );
  end

  // Idle flags are already registered per bit; the vector is stable only when every bit is idle.
  assign all_stable = &idle;

endmodule

// File: tb/tb_lab1_switch_debounce.sv
`timescale 1ns/1ps
module tb_lab1_switch_debounce;

  localparam int W    = 4;
  localparam int SYNC = 2;
  localparam int N    = 8;
  localparam int CW   = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] sw_in = '0;
  logic [W-1:0] sw_out;
  logic         all_stable;
`ifdef LAB1_SW_EDGE_EVT_EN
  logic [W-1:0] edge_pulse;
`endif

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  lab1_switch_debounce #(
    .WIDTH(W), .SYNC_STAGES(SYNC), .STABLE_CYCLES(N), .CNT_W(CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sw_in     (sw_in),
    .sw_out    (sw_out),
    .all_stable(all_stable)
`ifdef LAB1_SW_EDGE_EVT_EN
    ,
    .edge_pulse(edge_pulse)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, act, lo, hi, $time);
    end
  endtask

  // Reference model: the pin is seen SYNC cycles late; a bit adopts a new level once the
  // last N seen samples all hold that level.
  logic [W-1:0] dq[$];
  logic [W-1:0] hist[$];
  logic [W-1:0] m_out = '0;
  logic [W-1:0] m_old;
  logic [W-1:0] m_edge = '0;
  logic [W-1:0] m_s;
  logic         m_stable = 1'b1;
  bit           m_all;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      dq.delete();
      hist.delete();
      for (int k = 0; k < SYNC; k++) dq.push_back('0);
      for (int k = 0; k < N; k++) hist.push_back('0);
      m_out    = '0;
      m_edge   = '0;
      m_stable = 1'b1;
    end else begin
      m_s = dq.pop_front();
      dq.push_back(sw_in);
      hist.push_back(m_s);
      hist.delete(0);
      m_old = m_out;
      for (int i = 0; i < W; i++) begin
        m_all = 1'b1;
        for (int j = 0; j < N; j++) if (hist[j][i] != m_s[i]) m_all = 1'b0;
        if (m_all && m_s[i] != m_out[i]) m_out[i] = m_s[i];
      end
      m_edge   = m_out ^ m_old;
      m_stable = (m_s == m_out);
    end
  end

  // Compare the DUT with the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_sw_out", sw_out, m_out);
      check("model_all_stable", all_stable, m_stable);
`ifdef LAB1_SW_EDGE_EVT_EN
      check("model_edge_pulse", edge_pulse, m_edge);
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [W-1:0] val);
    tick(1);
    sw_in = val;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic wait_bit(input int b, input logic target, input int limit, output int n);
    n = 0;
    while (sw_out[b] !== target && n < limit) begin
      tick(1);
      n++;
    end
  endtask

  typedef struct {
    logic [W-1:0] in;
    int           hold;
    logic [W-1:0] exp_out;
    logic         exp_stable;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int n;
    int pulses;
    logic prev3;

    vecs[0]  = '{4'b0011, 12, 4'b0011, 1'b1};
    vecs[1]  = '{4'b0111,  5, 4'b0011, 1'b0};
    vecs[2]  = '{4'b0011, 12, 4'b0011, 1'b1};
    vecs[3]  = '{4'b1100, 12, 4'b1100, 1'b1};
    vecs[4]  = '{4'b1100,  3, 4'b1100, 1'b1};
    vecs[5]  = '{4'b0000,  9, 4'b1100, 1'b0};
    vecs[6]  = '{4'b0000,  1, 4'b0000, 1'b1};
    vecs[7]  = '{4'b1010, 10, 4'b1010, 1'b1};
    vecs[8]  = '{4'b0101,  2, 4'b1010, 1'b1};
    vecs[9]  = '{4'b0101,  1, 4'b1010, 1'b0};
    vecs[10] = '{4'b0101,  7, 4'b0101, 1'b1};

    // Reset held with all switches up, then release.
    sw_in = 4'hF;
    #1 reset = 1'b1;
    chk_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      check("t1_rst_out", sw_out, 4'h0);
      check("t1_rst_stable", all_stable, 1'b1);
    end
    reset = 1'b0;
    n = 0;
    while (sw_out !== 4'hF && n < 20) begin
      tick(1);
      n++;
    end
    check_range("t1_release_latency", n, 9, 11);
    check("t1_all_up", sw_out, 4'hF);

    // Clean step on bit 0.
    do_reset(4'h0);
    sw_in = 4'b0001;
    tick(5);
    check("t2_counting_stable", all_stable, 1'b0);
    check("t2_not_yet", sw_out, 4'h0);
    wait_bit(0, 1'b1, 15, n);
    check_range("t2_latency", n + 5, 9, 11);
    check("t2_out", sw_out, 4'b0001);

    // Bouncing bit 1, then held high.
    do_reset(4'h0);
    for (int k = 0; k < 10; k++) begin
      sw_in[1] = (k % 2 == 0);
      tick(3);
      check("t3_bounce_out", sw_out[1], 1'b0);
    end
    sw_in[1] = 1'b1;
    wait_bit(1, 1'b1, 20, n);
    check_range("t3_latency", n, 9, 11);

    // Short pulse on bit 2 is filtered.
    do_reset(4'h0);
    sw_in[2] = 1'b1;
    tick(7);
    sw_in[2] = 1'b0;
    n = 0;
    while (all_stable !== 1'b1 && n < 10) begin
      tick(1);
      n++;
    end
    check_range("t4_stable_return", n, 0, 3);
    tick(10);
    check("t4_no_change", sw_out, 4'h0);

    // Reset mid-count discards the pending change.
    do_reset(4'h0);
    sw_in[2] = 1'b1;
    tick(5);
    check("t5_counting", all_stable, 1'b0);
    reset = 1'b1;
    tick(1);
    check("t5_rst_out", sw_out, 4'h0);
    check("t5_rst_stable", all_stable, 1'b1);
    reset = 1'b0;
    wait_bit(2, 1'b1, 20, n);
    check_range("t5_full_window", n, 9, 11);
    check("t5_out", sw_out, 4'b0100);

`ifdef LAB1_SW_EDGE_EVT_EN
    // Edge strobes on bit 3 toggles.
    do_reset(4'h0);
    for (int ph = 0; ph < 2; ph++) begin
      sw_in[3] = (ph == 0);
      pulses = 0;
      prev3 = sw_out[3];
      for (int k = 0; k < 20; k++) begin
        tick(1);
        check("t6_other_bits", edge_pulse[2:0], 3'b000);
        if (edge_pulse[3]) begin
          pulses++;
          check("t6_coincident", sw_out[3], ~prev3);
        end
        prev3 = sw_out[3];
      end
      check("t6_pulse_count", pulses, 1);
      check("t6_level", sw_out[3], (ph == 0));
    end
`endif

    // Table of held input levels.
    do_reset(4'h0);
    for (int v = 0; v < 11; v++) begin
      sw_in = vecs[v].in;
      tick(vecs[v].hold);
      check($sformatf("vec%0d_out", v), sw_out, vecs[v].exp_out);
      check($sformatf("vec%0d_stable", v), all_stable, vecs[v].exp_stable);
    end

    // Random bouncing with occasional resets, checked against the model.
    do_reset(4'h0);
    for (int c = 0; c < 3000; c++) begin
      int den;
      den = ((c / 200) % 2 == 0) ? 3 : 20;
      for (int b = 0; b < W; b++) begin
        if ($urandom_range(0, den - 1) == 0) sw_in[b] = ~sw_in[b];
      end
      if ($urandom_range(0, 999) == 0) begin
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
      end
      tick(1);
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
